// File: rtl/grid_unloader.sv
// Readout engine for the PE array: waits a programmed number of cycles after start,
// snapshots the solution grid, then streams it row-major over valid/ready.
module grid_unloader #(
    parameter int N = 5,
    parameter int M = 5,
    parameter int W = 16
) (
    input  logic                         CLK,
    input  logic                         R,
    input  logic                         start,
    input  logic [15:0]                  iter_cnt,
    input  logic                         abort,
    input  logic [N-1:0][M-1:0][W-1:0]   uij,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [2:0]                   out_row,
    output logic [2:0]                   out_col,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam logic [2:0] LAST_ROW = 3'(N - 1);
    localparam logic [2:0] LAST_COL = 3'(M - 1);

    logic [1:0]                  state_q, state_d;
    logic [15:0]                 cnt_q, cnt_d;
    logic [N-1:0][M-1:0][W-1:0]  snap_q, snap_d;
    logic [2:0]                  row_q, row_d;
    logic [2:0]                  col_q, col_d;
    logic [W-1:0]                data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        last_q, last_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic                        hs;
    logic [2:0]                  nrow, ncol;

    assign hs = valid_q & out_ready;

    // Next word position in row-major order
    always_comb begin
        ncol = col_q + 3'd1;
        nrow = row_q;
        if (col_q == LAST_COL) begin
            ncol = 3'd0;
            nrow = row_q + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        row_d   = row_q;
        col_d   = col_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort) begin
            // Abort wins over start and over a same-cycle handshake; done stays low.
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_d   = iter_cnt;
                        state_d = S_WAIT;
                        busy_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        snap_d  = uij;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        data_d  = uij[0][0];
                        last_d  = (LAST_ROW == 3'd0) && (LAST_COL == 3'd0);
                        valid_d = 1'b1;
                        state_d = S_STREAM;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_STREAM: begin
                    if (hs) begin
                        if (last_q) begin
                            state_d = S_IDLE;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            row_d  = nrow;
                            col_d  = ncol;
                            data_d = snap_q[nrow][ncol];
                            last_d = (nrow == LAST_ROW) && (ncol == LAST_COL);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            snap_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            row_q   <= row_d;
            col_q   <= col_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_grid_unloader.sv
// Bench for grid_unloader: vector table of stream runs checked through an expected-word
// queue, plus hand-written abort, reset-mid-stream and done-cycle restart sequences.
module tb_grid_unloader;

    localparam int N = 5;
    localparam int M = 5;
    localparam int W = 16;

    logic                        CLK = 1'b0;
    logic                        R = 1'b0;
    logic                        start = 1'b0;
    logic [15:0]                 iter_cnt = '0;
    logic                        abort = 1'b0;
    logic [N-1:0][M-1:0][W-1:0]  uij = '0;
    logic                        out_valid;
    logic                        out_ready = 1'b0;
    logic [W-1:0]                out_data;
    logic [2:0]                  out_row;
    logic [2:0]                  out_col;
    logic                        out_last;
    logic                        busy;
    logic                        done;

    grid_unloader #(.N(N), .M(M), .W(W)) dut (
        .CLK(CLK), .R(R), .start(start), .iter_cnt(iter_cnt), .abort(abort),
        .uij(uij), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] iter;
        bit          bp;       // pseudo-random out_ready
        logic [15:0] xr;       // grid pattern xor mask
        bit          isolate;  // overwrite uij with 0xFFFF once streaming
        bit          poke;     // pulse start (iter_cnt=0) during WAIT
        int          exp_lat;  // edges from start edge (inclusive) to out_valid
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   row;
        logic [2:0]   col;
        logic         last;
    } word_t;

    word_t sbq[$];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] grid_val(input logic [15:0] xr, input int r, input int c);
        return W'(16 * r + c) ^ xr;
    endfunction

    task automatic set_grid(input logic [15:0] xr);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                uij[r][c] = grid_val(xr, r, c);
    endtask

    task automatic push_expected(input logic [15:0] xr);
        word_t w;
        sbq.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++) begin
                w.data = grid_val(xr, r, c);
                w.row  = 3'(r);
                w.col  = 3'(c);
                w.last = (r == N - 1) && (c == M - 1);
                sbq.push_back(w);
            end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Issue start and wait for the first word; returns edges counted from the start edge.
    task automatic launch(input vec_t v, output int lat);
        set_grid(v.xr);
        push_expected(v.xr);
        start    = 1'b1;
        iter_cnt = v.iter;
        tick();
        start    = 1'b0;
        iter_cnt = 16'hBEEF;
        check("busy_after_start", busy, 1);
        lat = 1;
        while (!out_valid && lat < int'(v.iter) + 10) begin
            if (v.poke) begin
                start    = 1'b1;
                iter_cnt = 16'd0;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        if (v.isolate) set_grid(16'h0000 ^ 16'hFFFF) ;
        if (v.isolate)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < M; c++)
                    uij[r][c] = 16'hFFFF;
    endtask

    // Drain up to max_words words, comparing each cycle's presented word to the queue head.
    task automatic drain(input bit bp, input int max_words);
        int budget = 0;
        int taken  = 0;
        logic rdy;
        while (sbq.size() > 0 && taken < max_words && budget < 400) begin
            if (!out_valid) begin
                check("valid_in_stream", out_valid, 1);
                break;
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            check("data", out_data, sbq[0].data);
            check("row", out_row, sbq[0].row);
            check("col", out_col, sbq[0].col);
            check("last", out_last, sbq[0].last);
            if (rdy) begin
                void'(sbq.pop_front());
                taken++;
            end
            tick();
            budget++;
        end
        out_ready = 1'b0;
        if (budget >= 400) check("drain_timeout", 0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        launch(v, lat);
        check("first_word_latency", lat, v.exp_lat);
        drain(v.bp, N * M);
        check("words_remaining", sbq.size(), 0);
        check("done_pulse", done, 1);
        check("busy_after_last", busy, 0);
        check("valid_after_last", out_valid, 0);
        tick();
        check("done_one_cycle", done, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t v;
        int   lat;

        vecs[0] = '{iter: 16'd0, bp: 1'b0, xr: 16'h0000, isolate: 1'b0, poke: 1'b0, exp_lat: 2};
        vecs[1] = '{iter: 16'd3, bp: 1'b0, xr: 16'h0000, isolate: 1'b0, poke: 1'b0, exp_lat: 5};
        vecs[2] = '{iter: 16'd3, bp: 1'b1, xr: 16'h0000, isolate: 1'b0, poke: 1'b0, exp_lat: 5};
        vecs[3] = '{iter: 16'd2, bp: 1'b1, xr: 16'h1234, isolate: 1'b1, poke: 1'b0, exp_lat: 4};
        vecs[4] = '{iter: 16'd5, bp: 1'b0, xr: 16'hA5A5, isolate: 1'b0, poke: 1'b1, exp_lat: 7};
        vecs[5] = '{iter: 16'd1, bp: 1'b1, xr: 16'h0F0F, isolate: 1'b1, poke: 1'b1, exp_lat: 3};

        // Reset held with random inputs: every output must stay zero.
        for (int i = 0; i < 4; i++) begin
            start     = 1'($urandom_range(0, 1));
            abort     = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            iter_cnt  = 16'($urandom);
            for (int r = 0; r < N; r++)
                for (int c = 0; c < M; c++)
                    uij[r][c] = 16'($urandom);
            tick();
        end
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        R = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            tick();
        end

        // Abort after 7 words, with a same-cycle handshake that abort must override.
        v = vecs[1];
        launch(v, lat);
        check("abort_latency", lat, 5);
        drain(1'b0, 7);
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_last", out_last, 0);
        check("abort_done", done, 0);
        tick();
        check("abort_done_later", done, 0);
        check("abort_idle_busy", busy, 0);
        run_vec(vecs[0]);

        // Reset dropped after 12 words: outputs clear without waiting for an edge.
        launch(vecs[2], lat);
        drain(1'b0, 12);
        #2 R = 1'b0;
        #1;
        check("mrst_valid", out_valid, 0);
        check("mrst_data", out_data, 0);
        check("mrst_row", out_row, 0);
        check("mrst_col", out_col, 0);
        check("mrst_busy", busy, 0);
        tick();
        R = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mrst_stay_idle_valid", out_valid, 0);
        check("mrst_stay_idle_busy", busy, 0);
        out_ready = 1'b0;
        run_vec(vecs[1]);

        // Start issued in the done cycle must be accepted.
        launch(vecs[0], lat);
        drain(1'b0, N * M);
        check("b2b_done", done, 1);
        v = vecs[1];
        launch(v, lat);
        check("b2b_latency", lat, 5);
        drain(1'b0, N * M);
        check("b2b_words", sbq.size(), 0);
        check("b2b_done2", done, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grid_unloader.md
# grid_unloader

Readout engine for the 5x5 PDE processing-element array. On a start command it lets the array iterate for a programmed number of clock cycles, then captures the array's solution grid into a snapshot register and streams it out one 16-bit word per transfer over a valid/ready interface. It sits between the array's solution outputs and the host or downstream consumer. Word order is row-major, each word tagged with its row and column.

## Interface
- N, 5, grid rows
- M, 5, grid columns
- W, 16, word width of each grid value
- CLK  input  1  clock; all state changes on rising edge
- R  input  1  asynchronous active-low reset
- start  input  1  start command; accepted only in IDLE
- iter_cnt  input  16  number of iteration cycles to wait before capture; sampled with an accepted start
- abort  input  1  synchronous abort; returns to IDLE from any state
- uij  input  W x [N-1:0][M-1:0]  solution grid from the PE array
- out_valid  output  1  out_data/out_row/out_col/out_last are valid
- out_ready  input  1  consumer accepts the current word
- out_data  output  W  grid word
- out_row  output  3  row index of out_data
- out_col  output  3  column index of out_data
- out_last  output  1  current word is the final one (row N-1, col M-1)
- busy  output  1  high in WAIT and STREAM
- done  output  1  one-cycle pulse after the last word is transferred

## Operation
- States: IDLE, WAIT, STREAM.
- IDLE: out_valid=0, busy=0. start=1 at an edge: load down-counter with iter_cnt, go to WAIT. start in WAIT or STREAM is ignored.
- WAIT: at each edge, if counter==0, capture all N*M uij values into the snapshot, set row=col=0, go to STREAM; otherwise decrement the counter.
- STREAM: out_valid=1. out_data=snapshot[row][col]. out_last=1 when row==N-1 and col==M-1. Handshake occurs at an edge with out_valid and out_ready both high. On a handshake: col increments; at col==M-1 col wraps to 0 and row increments. On the handshake of the last word go to IDLE and set done for one cycle.
- Once out_valid is high, out_data, out_row, out_col and out_last hold until a handshake or abort occurs.
- The snapshot is frozen from capture to the end of the stream. uij changes during STREAM do not affect the outputs.
- abort=1 at any edge forces IDLE, clears out_valid, out_last and busy, and does not raise done. Abort has priority over start and over a same-cycle handshake.
- Reset (R=0, asynchronous): state=IDLE, out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, busy=0, done=0, counter=0, snapshot=0. Reset mid-stream discards the remainder of the stream.

## Timing
- The start edge is t0. The capture edge is t0+iter_cnt+1, so iter_cnt=0 captures at t0+1.
- out_valid rises in the cycle after the capture edge, with word (0,0) presented.
- With out_ready held high: one word per cycle, N*M=25 cycles, no bubbles.
- done is high in the cycle after the last handshake, coincident with the return to IDLE (busy=0). A start during that cycle is accepted.
- Start-to-first-word latency is iter_cnt+2 edges. From the start edge, all 25 words complete after iter_cnt+26 edges at full throughput.
- All outputs are registered. There is no combinational path from out_ready to out_valid.

## Test plan
- Reset: hold R=0 with random inputs -> every output is 0. Release R, then drive start=1 with iter_cnt=0 -> busy=1 after one edge, out_valid=1 after two edges.
- Full stream: uij[r][c]=16*r+c, iter_cnt=3, out_ready=1 -> out_valid rises 5 edges after start. out_data runs 0x00,0x01,…,0x04,0x10,…,0x44 with matching out_row/out_col. out_last is high only on 0x44. done pulses once. Exactly 25 words.
- Backpressure: toggle out_ready pseudo-randomly -> no words lost or duplicated, and outputs stay stable while out_valid=1 and out_ready=0. The sequence matches the full-stream case.
- Snapshot isolation: after capture, set all uij to 0xFFFF -> streamed data still equals the captured values.
- Abort/ignored start: pulse start during WAIT -> counter is not reloaded and capture timing is unchanged. Assert abort after word 7 -> out_valid=0 and busy=0 on the next cycle, with no done. A fresh start then streams from (0,0).
- Reset mid-stream: drop R after word 12 -> outputs are 0 immediately (asynchronously). After release, the block stays IDLE until the next start.
